// File: rtl/addr_wcnt_gen_if.sv
// rtl/addr_wcnt_gen_if.sv - control/status bundle of the address / word-count generator
interface addr_wcnt_gen_if #(
  parameter int W = 8
);
  logic [W-1:0] data;
  logic         lda;
  logic         ldw;
  logic         reinit;
  logic [1:0]   mode;
  logic         go;
  logic         step;
  logic         dec;
  logic         aci;
  logic [W-1:0] addr;
  logic [W-1:0] wcnt;
  logic         busy;
  logic         done;
  logic         aco;

  modport master (
    output data, lda, ldw, reinit, mode, go, step, dec, aci,
    input  addr, wcnt, busy, done, aco
  );

  modport slave (
    input  data, lda, ldw, reinit, mode, go, step, dec, aci,
    output addr, wcnt, busy, done, aco
  );
endinterface

// File: rtl/addr_wcnt_gen.sv
// rtl/addr_wcnt_gen.sv - DMA-style address / word-count generator with IDLE/RUN/DONE sequencing
// Optional ADDR_WCNT_AUTO_RELOAD_EN: reload counters on terminal and keep running.
module addr_wcnt_gen #(
  parameter int           W        = 8,
  parameter logic [W-1:0] RST_ADDR = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  addr_wcnt_gen_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  localparam logic [1:0]   M_DOWN  = 2'b00;
  localparam logic [1:0]   M_UPCMP = 2'b01;
  localparam logic [1:0]   M_ACMP  = 2'b10;
  localparam logic [W-1:0] ONE     = W'(1);

  state_t       state;
  logic [W-1:0] addr_reg, word_reg, addr_cnt, wcnt_q;
  logic [1:0]   mode_l, eff_mode;
  logic         busy_q, done_q;
  logic         any_ld, step_acc, terminal;
  logic [W-1:0] addr_nxt, wcnt_nxt, wcnt_ld, wcnt_rl;

  // Modes 01/10 use wcnt as an upward tally, so it restarts from zero instead of the load value.
  function automatic logic tally_mode(input logic [1:0] m);
    return (m == M_UPCMP) || (m == M_ACMP);
  endfunction

  // While running the latched mode rules; otherwise the live mode input decides load behaviour.
  assign eff_mode = (state == RUN) ? mode_l : bus.mode;
  assign wcnt_ld  = tally_mode(eff_mode) ? '0 : bus.data;
  assign wcnt_rl  = tally_mode(eff_mode) ? '0 : word_reg;
  assign any_ld   = bus.lda | bus.ldw;
  assign step_acc = rst_n & (state == RUN) & bus.step & ~bus.reinit & ~any_ld;

  assign addr_nxt = bus.aci ? addr_cnt : (bus.dec ? addr_cnt - ONE : addr_cnt + ONE);
  assign wcnt_nxt = (mode_l == M_DOWN) ? wcnt_q - ONE : wcnt_q + ONE;

  always_comb begin
    terminal = 1'b0;
    case (mode_l)
      M_DOWN:  terminal = (wcnt_q == ONE);
      M_UPCMP: terminal = (wcnt_nxt == word_reg);
      M_ACMP:  terminal = (addr_nxt == word_reg);
      default: terminal = 1'b0;
    endcase
  end

  assign bus.aco  = step_acc & ~bus.aci & (bus.dec ? (addr_cnt == '0) : (addr_cnt == '1));
  assign bus.addr = addr_cnt;
  assign bus.wcnt = wcnt_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_reg <= RST_ADDR;
      addr_cnt <= RST_ADDR;
      word_reg <= '0;
      wcnt_q   <= '0;
      mode_l   <= M_DOWN;
      state    <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else if (bus.reinit) begin
      addr_cnt <= addr_reg;
      wcnt_q   <= wcnt_rl;
      state    <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else if (any_ld) begin
      if (bus.lda) begin
        addr_reg <= bus.data;
        addr_cnt <= bus.data;
      end
      if (bus.ldw) begin
        word_reg <= bus.data;
        wcnt_q   <= wcnt_ld;
      end
      if (state == DONE) state <= IDLE;
      done_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.go) begin
            state  <= RUN;
            busy_q <= 1'b1;
            mode_l <= bus.mode;
          end
        end
        RUN: begin
          done_q <= 1'b0;
          if (bus.step) begin
            if (terminal) begin
`ifdef ADDR_WCNT_AUTO_RELOAD_EN
              addr_cnt <= addr_reg;
              wcnt_q   <= wcnt_rl;
              done_q   <= 1'b1;
`else
              addr_cnt <= addr_nxt;
              wcnt_q   <= wcnt_nxt;
              state    <= DONE;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
`endif
            end else begin
              addr_cnt <= addr_nxt;
              wcnt_q   <= wcnt_nxt;
            end
          end
        end
        DONE: begin
          if (bus.go) begin
            state  <= IDLE;
            done_q <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_addr_wcnt_gen.sv
// tb/tb_addr_wcnt_gen.sv - self-checking bench for addr_wcnt_gen (vector table, directed and random)
module tb_addr_wcnt_gen;
  localparam int         W  = 8;
  localparam logic [7:0] RA = 8'h3C;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  addr_wcnt_gen_if #(.W(W)) bus();
  addr_wcnt_gen #(.W(W), .RST_ADDR(RA)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int   n_err = 0;
  int   n_chk = 0;
  bit   mchk  = 1'b0;
  logic s_aco;

  // Reference: phase 0 idle, 1 running, 2 finished; values kept as plain integers mod 256.
  int m_areg = 0, m_wreg = 0, m_addr = 0, m_wcnt = 0, m_mode = 0, m_phase = 0;
  bit m_done = 1'b0;

  typedef struct {
    logic       r;
    logic [7:0] d;
    logic       la, lw, ri;
    logic [1:0] md;
    logic       g, s, dc, ac;
    logic [7:0] ea, ew;
    logic       eb, ed, eaco;
  } vec_t;

  vec_t tv[24];
  int   n_tv;

  function automatic vec_t v(logic r, logic [7:0] d, logic la, logic lw, logic ri, logic [1:0] md,
                             logic g, logic s, logic dc, logic ac,
                             logic [7:0] ea, logic [7:0] ew, logic eb, logic ed, logic eaco);
    vec_t t;
    t.r = r; t.d = d; t.la = la; t.lw = lw; t.ri = ri; t.md = md;
    t.g = g; t.s = s; t.dc = dc; t.ac = ac;
    t.ea = ea; t.ew = ew; t.eb = eb; t.ed = ed; t.eaco = eaco;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int zero_for_tally(int md, int val);
    return (md == 1 || md == 2) ? 0 : val;
  endfunction

  task automatic model_edge(input logic r, input logic [7:0] d, input logic la, input logic lw,
                            input logic ri, input logic [1:0] md, input logic g, input logic s,
                            input logic dc, input logic ac);
    int em, na, nw;
    bit fin;
    em = (m_phase == 1) ? m_mode : int'(md);
    if (!r) begin
      m_areg = RA; m_addr = RA; m_wreg = 0; m_wcnt = 0; m_mode = 0; m_phase = 0; m_done = 0;
    end else if (ri) begin
      m_addr = m_areg; m_wcnt = zero_for_tally(em, m_wreg); m_phase = 0; m_done = 0;
    end else if (la || lw) begin
      if (la) begin m_areg = d; m_addr = d; end
      if (lw) begin m_wreg = d; m_wcnt = zero_for_tally(em, d); end
      if (m_phase == 2) m_phase = 0;
      m_done = 0;
    end else if (m_phase == 0) begin
      if (g) begin m_phase = 1; m_mode = md; end
    end else if (m_phase == 2) begin
      if (g) begin m_phase = 0; m_done = 0; end
    end else begin
      m_done = 0;
      if (s) begin
        na  = ac ? m_addr : (m_addr + (dc ? 255 : 1)) % 256;
        nw  = (m_wcnt + ((m_mode == 0) ? 255 : 1)) % 256;
        fin = (m_mode == 0) ? (nw == 0) : (m_mode == 1) ? (nw == m_wreg) :
              (m_mode == 2) ? (na == m_wreg) : 1'b0;
`ifdef ADDR_WCNT_AUTO_RELOAD_EN
        if (fin) begin
          m_addr = m_areg; m_wcnt = zero_for_tally(m_mode, m_wreg); m_done = 1;
        end else begin
          m_addr = na; m_wcnt = nw;
        end
`else
        m_addr = na; m_wcnt = nw;
        if (fin) begin m_phase = 2; m_done = 1; end
`endif
      end
    end
  endtask

  task automatic cyc(input logic r, input logic [7:0] d, input logic la, input logic lw,
                     input logic ri, input logic [1:0] md, input logic g, input logic s,
                     input logic dc, input logic ac);
    bit e_aco;
    rst_n = r; bus.data = d; bus.lda = la; bus.ldw = lw; bus.reinit = ri;
    bus.mode = md; bus.go = g; bus.step = s; bus.dec = dc; bus.aci = ac;
    e_aco = r && m_phase == 1 && s && !ri && !la && !lw && !ac &&
            (dc ? (m_addr == 0) : (m_addr == 255));
    @(negedge clk);
    s_aco = bus.aco;
    if (mchk) chk("model_aco", 32'(s_aco), 32'(e_aco));
    @(posedge clk);
    model_edge(r, d, la, lw, ri, md, g, s, dc, ac);
    #1;
    if (mchk) begin
      chk("model_addr", 32'(bus.addr), m_addr);
      chk("model_wcnt", 32'(bus.wcnt), m_wcnt);
      chk("model_busy", 32'(bus.busy), 32'(m_phase == 1));
      chk("model_done", 32'(bus.done), 32'(m_done));
    end
  endtask

  task automatic idle_cyc(input logic r);
    cyc(r, 8'h00, 0, 0, 0, 2'b00, 0, 0, 0, 0);
  endtask

  initial begin
    bit   early;
    logic [4:0] dpat;
    rst_n = 1'b0; bus.data = '0; bus.lda = 0; bus.ldw = 0; bus.reinit = 0;
    bus.mode = 2'b00; bus.go = 0; bus.step = 0; bus.dec = 0; bus.aci = 0;
    @(posedge clk); #1;

    // Vector table: basic count-down, free-run wrap with aci, address-compare count-down.
    tv[0]  = v(0, 8'h00, 0, 0, 0, 2'b00, 0, 0, 0, 0, RA,    8'h00, 0, 0, 0);
    tv[1]  = v(1, 8'h10, 1, 0, 0, 2'b00, 0, 0, 0, 0, 8'h10, 8'h00, 0, 0, 0);
    tv[2]  = v(1, 8'h03, 0, 1, 0, 2'b00, 0, 0, 0, 0, 8'h10, 8'h03, 0, 0, 0);
    tv[3]  = v(1, 8'h00, 0, 0, 0, 2'b00, 1, 0, 0, 0, 8'h10, 8'h03, 1, 0, 0);
    tv[4]  = v(1, 8'h00, 0, 0, 0, 2'b00, 0, 1, 0, 0, 8'h11, 8'h02, 1, 0, 0);
    tv[5]  = v(1, 8'h00, 0, 0, 0, 2'b00, 0, 1, 0, 0, 8'h12, 8'h01, 1, 0, 0);
`ifdef ADDR_WCNT_AUTO_RELOAD_EN
    tv[6]  = v(1, 8'h00, 0, 0, 0, 2'b00, 0, 1, 0, 0, 8'h10, 8'h03, 1, 1, 0);
    tv[7]  = v(1, 8'h00, 0, 0, 0, 2'b00, 0, 1, 0, 0, 8'h11, 8'h02, 1, 0, 0);
`else
    tv[6]  = v(1, 8'h00, 0, 0, 0, 2'b00, 0, 1, 0, 0, 8'h13, 8'h00, 0, 1, 0);
    tv[7]  = v(1, 8'h00, 0, 0, 0, 2'b00, 0, 1, 0, 0, 8'h13, 8'h00, 0, 1, 0);
`endif
    tv[8]  = v(1, 8'h00, 0, 0, 1, 2'b00, 0, 0, 0, 0, 8'h10, 8'h03, 0, 0, 0);
    tv[9]  = v(1, 8'hFF, 1, 0, 0, 2'b11, 0, 0, 0, 0, 8'hFF, 8'h03, 0, 0, 0);
    tv[10] = v(1, 8'h00, 0, 0, 0, 2'b11, 1, 1, 0, 0, 8'hFF, 8'h03, 1, 0, 0);
    tv[11] = v(1, 8'h00, 0, 0, 0, 2'b00, 0, 1, 0, 0, 8'h00, 8'h04, 1, 0, 1);
    tv[12] = v(1, 8'hFF, 1, 0, 0, 2'b11, 0, 1, 0, 0, 8'hFF, 8'h04, 1, 0, 0);
    tv[13] = v(1, 8'h00, 0, 0, 0, 2'b01, 0, 1, 0, 1, 8'hFF, 8'h05, 1, 0, 0);
    tv[14] = v(1, 8'h00, 0, 0, 1, 2'b10, 0, 0, 0, 0, 8'hFF, 8'h03, 0, 0, 0);
    tv[15] = v(1, 8'h05, 1, 0, 0, 2'b10, 0, 0, 0, 0, 8'h05, 8'h03, 0, 0, 0);
    tv[16] = v(1, 8'h02, 0, 1, 0, 2'b10, 0, 0, 0, 0, 8'h05, 8'h00, 0, 0, 0);
    tv[17] = v(1, 8'h00, 0, 0, 0, 2'b10, 1, 0, 1, 0, 8'h05, 8'h00, 1, 0, 0);
    tv[18] = v(1, 8'h00, 0, 0, 0, 2'b00, 0, 1, 1, 0, 8'h04, 8'h01, 1, 0, 0);
    tv[19] = v(1, 8'h00, 0, 0, 0, 2'b00, 0, 1, 1, 0, 8'h03, 8'h02, 1, 0, 0);
`ifdef ADDR_WCNT_AUTO_RELOAD_EN
    tv[20] = v(1, 8'h00, 0, 0, 0, 2'b00, 0, 1, 1, 0, 8'h05, 8'h00, 1, 1, 0);
    tv[21] = v(1, 8'h00, 0, 0, 0, 2'b00, 1, 0, 0, 0, 8'h05, 8'h00, 1, 0, 0);
`else
    tv[20] = v(1, 8'h00, 0, 0, 0, 2'b00, 0, 1, 1, 0, 8'h02, 8'h03, 0, 1, 0);
    tv[21] = v(1, 8'h00, 0, 0, 0, 2'b00, 1, 0, 0, 0, 8'h02, 8'h03, 0, 0, 0);
`endif
    tv[22] = v(0, 8'h00, 0, 0, 0, 2'b00, 0, 1, 0, 0, RA,    8'h00, 0, 0, 0);
    n_tv = 23;

    for (int i = 0; i < n_tv; i++) begin
      cyc(tv[i].r, tv[i].d, tv[i].la, tv[i].lw, tv[i].ri, tv[i].md,
          tv[i].g, tv[i].s, tv[i].dc, tv[i].ac);
      chk($sformatf("tv%0d_aco", i),  32'(s_aco),    32'(tv[i].eaco));
      chk($sformatf("tv%0d_addr", i), 32'(bus.addr), 32'(tv[i].ea));
      chk($sformatf("tv%0d_wcnt", i), 32'(bus.wcnt), 32'(tv[i].ew));
      chk($sformatf("tv%0d_busy", i), 32'(bus.busy), 32'(tv[i].eb));
      chk($sformatf("tv%0d_done", i), 32'(bus.done), 32'(tv[i].ed));
    end

    // A loaded count of zero runs the full 2^W transfers.
    cyc(1, 8'h80, 1, 0, 0, 2'b00, 0, 0, 0, 0);
    cyc(1, 8'h00, 0, 1, 0, 2'b00, 0, 0, 0, 0);
    cyc(1, 8'h00, 0, 0, 0, 2'b00, 1, 0, 0, 0);
    early = 1'b0;
    for (int i = 0; i < 255; i++) begin
      cyc(1, 8'h00, 0, 0, 0, 2'b00, 0, 1, 0, 0);
      if (bus.done !== 1'b0 || bus.busy !== 1'b1) early = 1'b1;
    end
    chk("full_count_no_early_done", 32'(early), 32'd0);
    cyc(1, 8'h00, 0, 0, 0, 2'b00, 0, 1, 0, 0);
    chk("full_count_done", 32'(bus.done), 32'd1);
    chk("full_count_wcnt", 32'(bus.wcnt), 32'h00);
    chk("full_count_addr", 32'(bus.addr), 32'h80);
`ifdef ADDR_WCNT_AUTO_RELOAD_EN
    chk("full_count_busy", 32'(bus.busy), 32'd1);
`else
    chk("full_count_busy", 32'(bus.busy), 32'd0);
`endif

    // Reset mid-run aborts the transfer; aco is masked during reset.
    idle_cyc(0);
    cyc(1, 8'hFF, 1, 0, 0, 2'b00, 0, 0, 0, 0);
    cyc(1, 8'h05, 0, 1, 0, 2'b00, 0, 0, 0, 0);
    cyc(1, 8'h00, 0, 0, 0, 2'b00, 1, 0, 0, 0);
    cyc(1, 8'h00, 0, 0, 0, 2'b00, 0, 1, 0, 0);
    chk("rst_pre_aco", 32'(s_aco), 32'd1);
    cyc(0, 8'h00, 0, 0, 0, 2'b00, 0, 1, 1, 0);
    chk("rst_aco_masked", 32'(s_aco), 32'd0);
    chk("rst_addr", 32'(bus.addr), 32'(RA));
    chk("rst_wcnt", 32'(bus.wcnt), 32'h00);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);

`ifdef ADDR_WCNT_AUTO_RELOAD_EN
    // Up-compare with reload: done pulses after every second step.
    cyc(1, 8'h02, 0, 1, 0, 2'b01, 0, 0, 0, 0);
    cyc(1, 8'h00, 0, 0, 0, 2'b01, 1, 0, 0, 0);
    dpat = '0;
    for (int i = 0; i < 5; i++) begin
      cyc(1, 8'h00, 0, 0, 0, 2'b01, 0, 1, 0, 0);
      dpat[i] = bus.done;
    end
    chk("reload_done_pattern", 32'(dpat), 32'b01010);
    chk("reload_busy", 32'(bus.busy), 32'd1);
    chk("reload_wcnt", 32'(bus.wcnt), 32'h01);
`else
    dpat = '0;
`endif

    // Random traffic against the reference model.
    idle_cyc(0);
    mchk = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      logic [7:0] rd;
      rd = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 12));
      cyc(($urandom_range(0, 149) != 0), rd,
          ($urandom_range(0, 24) == 0), ($urandom_range(0, 24) == 0),
          ($urandom_range(0, 59) == 0), 2'($urandom_range(0, 3)),
          ($urandom_range(0, 5) == 0), ($urandom_range(0, 9) < 7),
          1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0));
    end
    mchk = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/addr_wcnt_gen.md
ADDR_WCNT_GEN -- requirements
Module: addr_wcnt_gen

Interface
REQ-001 SHALL have parameter W, default 8, giving the address and word-count width (4..32).
REQ-002 SHALL have parameter RST_ADDR, default 0, giving the address reset value.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
REQ-005 data  in  W  load data for the address or word-count registers.
REQ-006 lda  in  1  load address register and address counter from data.
REQ-007 ldw  in  1  load word register and word counter from data.
REQ-008 reinit  in  1  copy the registers back into the counters and enter IDLE.
REQ-009 mode  in  2  00 word-count down; 01 word-count up-compare; 10 address compare; 11 free-run.
REQ-010 go  in  1  start pulse, IDLE->RUN.
REQ-011 step  in  1  advance one transfer while in RUN.
REQ-012 dec  in  1  address direction: 0 increments, 1 decrements.
REQ-013 aci  in  1  carry-in inhibit: 1 blocks the address change on a step; the word counter still advances.
REQ-014 addr  out  W  address counter.
REQ-015 wcnt  out  W  word counter.
REQ-016 busy  out  1  high in RUN.
REQ-017 done  out  1  high in DONE; pulses for one cycle under AUTO_RELOAD_EN.
REQ-018 aco  out  1  combinational; high when a step this cycle wraps addr (all-ones with inc, zero with dec) and aci=0.

Function
REQ-019 FSM states SHALL be IDLE, RUN and DONE.
- IDLE->RUN on go.
- RUN->DONE on the step that meets terminal.
- DONE->IDLE on go, reinit or any load.
REQ-020 A step in RUN SHALL be the only event that moves counters; steps in IDLE or DONE are ignored.
REQ-021 Address SHALL move by +1/-1 modulo 2^W per accepted step; wrap permitted in all modes.
REQ-022 Mode 00: wcnt decrements per step; terminal when wcnt=1 before step, leaving wcnt=0.
- A loaded count of 0 SHALL mean 2^W transfers.
REQ-023 Mode 01: wcnt starts at 0, increments per step; terminal when post-step wcnt equals word register.
- A word register of 0 SHALL mean 2^W transfers.
REQ-024 Mode 10: terminal when post-step addr equals word register.
- wcnt increments as a transfer tally.
REQ-025 Mode 11: never terminal; wcnt increments, wraps silently.
REQ-026 Loads SHALL take effect next cycle in any state.
- Priority: rst_n > reinit > lda/ldw > step.
- lda and ldw together both load.
REQ-027 ldw in mode 01 SHALL load the word register from data and set wcnt=0.
REQ-028 go and step in the same IDLE cycle SHALL enter RUN without counting.
REQ-029 mode changes while busy=1 SHALL be ignored; mode is latched on go.
REQ-030 aci=1 on the terminal step SHALL still terminate (mode 00/01); addr holds.

Reset
REQ-031 rst_n=0 SHALL set:
- addr and address register = RST_ADDR.
- wcnt and word register = 0.
- state = IDLE, busy=0, done=0, latched mode=00.
REQ-032 Reset mid-RUN SHALL abort the transfer with no done pulse.
REQ-033 aco SHALL be 0 during reset.

Configuration
REQ-034 Macro ADDR_WCNT_AUTO_RELOAD_EN, when defined: on the terminal step the counters SHALL reload from the registers next cycle and remain in RUN, with done high for exactly that one cycle.
REQ-035 Macro undefined: FSM SHALL stay in DONE with done held high and counters frozen until go, reinit or a load.

Verification
REQ-036 W=8, mode 00, lda 0x10, ldw 3, go, 3 steps (dec=0) -> addr 0x13, wcnt 0, done=1 after third step, busy=0.
REQ-037 Mode 00, ldw 0, go, 256 steps -> done only after step 256; wcnt 0; addr advanced by 256 (back to start).
REQ-038 Mode 11, lda 0xFF, dec=0, step -> aco=1 in step cycle, addr 0x00 next; with aci=1 -> aco=0, addr stays 0xFF.
REQ-039 Mode 10, lda 0x05, ldw 0x02, dec=1, go, 3 steps -> done after third step, addr 0x02, wcnt 3.
REQ-040 ADDR_WCNT_AUTO_RELOAD_EN, mode 01, ldw 2, go, 5 steps -> done pulses after steps 2 and 4; busy stays 1; wcnt 1 at end.
REQ-041 rst_n=0 asserted mid-RUN with step=1 -> next cycle addr=RST_ADDR, wcnt 0, busy 0, done 0.
